// File: rtl/fifo_to_mem_ring.sv
// Drains a first-word-fall-through FIFO into a memory write port over [low, high), one-shot or ring.
// Optional FIFO_TO_MEM_RING_CNT_EN adds the wr_count and wrap_count run statistics outputs.
module fifo_to_mem_ring #(
    parameter int FIFO_DATA_WIDTH  = 144,
    parameter int MEM_ADDR_WIDTH   = 19,
    parameter int MEM_DATA_WIDTH   = 144,
    parameter int MEM_BURST_LENGTH = 4,
    parameter int MEM_ADDR_LOW     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
    input  logic                       fifo_empty,
    output logic                       app_wr_cmd,
    input  logic                       app_wr_rdy,
    output logic [MEM_ADDR_WIDTH-1:0]  app_wr_addr,
    output logic [MEM_DATA_WIDTH-1:0]  app_wr_data,
    input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]  dflow_addr_high,
    output logic [MEM_ADDR_WIDTH-1:0]  dflow_mem_high,
    input  logic                       wrap_mode,
    input  logic                       start_store,
    input  logic                       cal_done,
    input  logic                       sw_rst,
    output logic                       store_done
`ifdef FIFO_TO_MEM_RING_CNT_EN
    ,
    output logic [31:0]                wr_count,
    output logic [15:0]                wrap_count
`endif
);

    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_IDLE  = MEM_ADDR_WIDTH'(MEM_ADDR_LOW);
    localparam logic [MEM_ADDR_WIDTH-1:0] BURST_MASK = MEM_ADDR_WIDTH'(MEM_BURST_LENGTH - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE   = MEM_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {IDLE, RUN, STOP, DRAIN, DONE} state_t;

    state_t                    state_r;
    logic [MEM_ADDR_WIDTH-1:0] low_r;
    logic [MEM_ADDR_WIDTH-1:0] high_r;
    logic [MEM_ADDR_WIDTH-1:0] wp_r;
    logic                      wrap_r;
    logic                      oneshot_end_r;

    logic                      free_s;
    logic                      accept_s;
    logic                      aligned_s;
    logic                      win_end_s;
    logic                      pop_ok_s;
    logic [MEM_ADDR_WIDTH-1:0] wp_next_s;
    logic [MEM_ADDR_WIDTH-1:0] acc_next_s;

    assign free_s     = !app_wr_cmd || app_wr_rdy;
    assign accept_s   = app_wr_cmd && app_wr_rdy;
    assign wp_next_s  = wp_r + ADDR_ONE;
    assign acc_next_s = app_wr_addr + ADDR_ONE;
    assign win_end_s  = (wp_next_s == high_r);
    assign aligned_s  = (((wp_r - low_r) & BURST_MASK) == '0);
    // STOP keeps popping only to fill out the current burst
    assign pop_ok_s   = (state_r == RUN) || ((state_r == STOP) && !aligned_s);
    assign fifo_rd_en = free_s && !fifo_empty && cal_done && pop_ok_s;

    // Run control, write output register, high-water tracking and optional counters
    always_ff @(posedge clk) begin
        if (!rst_n || sw_rst) begin
            state_r        <= IDLE;
            low_r          <= '0;
            high_r         <= '0;
            wp_r           <= '0;
            wrap_r         <= 1'b0;
            oneshot_end_r  <= 1'b0;
            app_wr_cmd     <= 1'b0;
            app_wr_addr    <= ADDR_IDLE;
            app_wr_data    <= '0;
            dflow_mem_high <= dflow_addr_low;
            store_done     <= 1'b0;
`ifdef FIFO_TO_MEM_RING_CNT_EN
            wr_count       <= 32'd0;
            wrap_count     <= 16'd0;
`endif
        end else begin
            if (fifo_rd_en) begin
                app_wr_cmd  <= 1'b1;
                app_wr_addr <= wp_r;
                app_wr_data <= MEM_DATA_WIDTH'(fifo_data);
                wp_r        <= (win_end_s && wrap_r) ? low_r : wp_next_s;
            end else if (free_s) begin
                app_wr_cmd <= 1'b0;
            end

            if (accept_s && (acc_next_s > dflow_mem_high)) begin
                dflow_mem_high <= acc_next_s;
            end

`ifdef FIFO_TO_MEM_RING_CNT_EN
            if (accept_s && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
            if (fifo_rd_en && win_end_s && wrap_r && (wrap_count != 16'hFFFF)) begin
                wrap_count <= wrap_count + 16'd1;
            end
`endif

            case (state_r)
                IDLE: begin
                    if (start_store) begin
                        low_r          <= dflow_addr_low;
                        high_r         <= dflow_addr_high;
                        wrap_r         <= wrap_mode;
                        wp_r           <= dflow_addr_low;
                        dflow_mem_high <= dflow_addr_low;
                        oneshot_end_r  <= 1'b0;
`ifdef FIFO_TO_MEM_RING_CNT_EN
                        wr_count       <= 32'd0;
                        wrap_count     <= 16'd0;
`endif
                        if (dflow_addr_high <= dflow_addr_low) begin
                            state_r    <= DONE;
                            store_done <= 1'b1;
                        end else begin
                            state_r    <= RUN;
                            store_done <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (fifo_rd_en && win_end_s && !wrap_r) begin
                        state_r       <= DRAIN;
                        oneshot_end_r <= 1'b1;
                    end else if (!start_store) begin
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (fifo_rd_en && win_end_s && !wrap_r) begin
                        state_r       <= DRAIN;
                        oneshot_end_r <= 1'b1;
                    end else if (aligned_s || fifo_empty) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!app_wr_cmd) begin
                        state_r     <= oneshot_end_r ? DONE : IDLE;
                        store_done  <= oneshot_end_r;
                        app_wr_addr <= ADDR_IDLE;
                    end
                end
                DONE: begin
                    if (!start_store) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_to_mem_ring.sv
// Directed self-checking bench for fifo_to_mem_ring: one-shot, backpressure, ring, burst stop, cal gating, soft reset.
module tb_fifo_to_mem_ring;

    logic          clk;
    logic          rst_n;
    logic          fifo_rd_en;
    logic [143:0]  fifo_data;
    logic          fifo_empty;
    logic          app_wr_cmd;
    logic          app_wr_rdy;
    logic [18:0]   app_wr_addr;
    logic [143:0]  app_wr_data;
    logic [18:0]   dflow_addr_low;
    logic [18:0]   dflow_addr_high;
    logic [18:0]   dflow_mem_high;
    logic          wrap_mode;
    logic          start_store;
    logic          cal_done;
    logic          sw_rst;
    logic          store_done;
`ifdef FIFO_TO_MEM_RING_CNT_EN
    logic [31:0]   wr_count;
    logic [15:0]   wrap_count;
`endif

    fifo_to_mem_ring dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_data       (fifo_data),
        .fifo_empty      (fifo_empty),
        .app_wr_cmd      (app_wr_cmd),
        .app_wr_rdy      (app_wr_rdy),
        .app_wr_addr     (app_wr_addr),
        .app_wr_data     (app_wr_data),
        .dflow_addr_low  (dflow_addr_low),
        .dflow_addr_high (dflow_addr_high),
        .dflow_mem_high  (dflow_mem_high),
        .wrap_mode       (wrap_mode),
        .start_store     (start_store),
        .cal_done        (cal_done),
        .sw_rst          (sw_rst),
        .store_done      (store_done)
`ifdef FIFO_TO_MEM_RING_CNT_EN
        ,
        .wr_count        (wr_count),
        .wrap_count      (wrap_count)
`endif
    );

    // FIFO model storage, write log and counters
    logic [143:0] fifo_mem [64];
    int           wr_ptr;
    int           rd_ptr;
    logic         flush;
    int           seq;
    logic [18:0]  waddr [64];
    logic [143:0] wdata [64];
    int           wcyc  [64];
    int           nwr;
    int           npop;
    int           cyc;
    int           total;
    int           bad;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = fifo_mem[rd_ptr[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO pop side and cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    // Log every write accepted at the coming edge, and every pop
    always @(negedge clk) begin
        if (app_wr_cmd && app_wr_rdy) begin
            waddr[nwr[5:0]] <= app_wr_addr;
            wdata[nwr[5:0]] <= app_wr_data;
            wcyc[nwr[5:0]]  <= cyc;
            nwr             <= nwr + 1;
        end
        if (fifo_rd_en) npop <= npop + 1;
    end

    function automatic logic [143:0] mk(input int i);
        return {16'hC0DE, 32'(i), 32'(i * 7), 64'h0123_4567_89AB_CDEF ^ 64'(i)};
    endfunction

    task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[5:0]] = mk(seq);
            seq    = seq + 1;
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int target, input int lim);
        int k;
        k = 0;
        while (nwr < target && k < lim) begin
            tick();
            k++;
        end
        if (nwr < target) check_eq("timeout_writes", 144'(nwr), 144'(target));
    endtask

    task automatic end_run();
        start_store = 1'b0;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, p0, b, k;
        wr_ptr = 0; rd_ptr = 0; flush = 1'b0; seq = 0; nwr = 0; npop = 0; cyc = 0;
        total = 0; bad = 0;
        rst_n = 1'b0; sw_rst = 1'b0; start_store = 1'b0; cal_done = 1'b1; app_wr_rdy = 1'b1;
        wrap_mode = 1'b0; dflow_addr_low = 19'h10; dflow_addr_high = 19'h14;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd",  144'(app_wr_cmd), 144'(0));
        check_eq("rst_addr", 144'(app_wr_addr), 144'(0));
        check_eq("rst_data", app_wr_data, 144'(0));
        check_eq("rst_memhigh", 144'(dflow_mem_high), 144'(19'h10));
        check_eq("rst_done", 144'(store_done), 144'(0));
        check_eq("rst_rden", 144'(fifo_rd_en), 144'(0));
        tick();
        rst_n = 1'b1;

        // One-shot 0x10..0x13 with six words queued
        n0 = nwr; p0 = npop; b = seq;
        push(6);
        start_store = 1'b1;
        wait_writes(n0 + 4, 30);
        k = 0;
        while (!store_done && k < 20) begin tick(); k++; end
        repeat (3) tick();
        @(negedge clk);
        check_eq("os_nwr", 144'(nwr - n0), 144'(4));
        check_eq("os_npop", 144'(npop - p0), 144'(4));
        for (int i = 0; i < 4; i++) begin
            check_eq("os_addr", 144'(waddr[n0 + i]), 144'(19'h10 + i));
            check_eq("os_data", wdata[n0 + i], mk(b + i));
        end
        check_eq("os_b2b", 144'(wcyc[n0 + 3] - wcyc[n0]), 144'(3));
        check_eq("os_left", 144'(wr_ptr - rd_ptr), 144'(2));
        check_eq("os_done", 144'(store_done), 144'(1));
        check_eq("os_memhigh", 144'(dflow_mem_high), 144'(19'h14));
        end_run();

        // Backpressure on the second write
        dflow_addr_low = 19'h20; dflow_addr_high = 19'h40;
        n0 = nwr; b = seq;
        push(4);
        start_store = 1'b1;
        k = 0;
        while (!(app_wr_cmd && app_wr_addr == 19'h21) && k < 20) begin tick(); k++; end
        if (k >= 20) check_eq("timeout_bp", 144'(app_wr_addr), 144'(19'h21));
        app_wr_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_rden", 144'(fifo_rd_en), 144'(0));
            check_eq("bp_cmd",  144'(app_wr_cmd), 144'(1));
            check_eq("bp_addr", 144'(app_wr_addr), 144'(19'h21));
            check_eq("bp_data", app_wr_data, mk(b + 1));
            tick();
        end
        app_wr_rdy = 1'b1;
        wait_writes(n0 + 4, 30);
        repeat (3) tick();
        check_eq("bp_nwr", 144'(nwr - n0), 144'(4));
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_addr_seq", 144'(waddr[n0 + i]), 144'(19'h20 + i));
            check_eq("bp_data_seq", wdata[n0 + i], mk(b + i));
        end
        check_eq("bp_clears_done", 144'(store_done), 144'(0));
        end_run();

        // Ring over [0,4) with ten words
        dflow_addr_low = 19'h0; dflow_addr_high = 19'h4; wrap_mode = 1'b1;
        n0 = nwr; b = seq;
        push(10);
        start_store = 1'b1;
        wait_writes(n0 + 10, 40);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("ring_addr", 144'(waddr[n0 + i]), 144'(i % 4));
            check_eq("ring_data", wdata[n0 + i], mk(b + i));
        end
        check_eq("ring_memhigh", 144'(dflow_mem_high), 144'(19'h4));
`ifdef FIFO_TO_MEM_RING_CNT_EN
        check_eq("ring_wraps", 144'(wrap_count), 144'(2));
        check_eq("ring_wrcnt", 144'(wr_count), 144'(10));
`endif
        end_run();
        wrap_mode = 1'b0;

        // Burst-aligned stop after the fifth pop, FIFO deep
        dflow_addr_low = 19'h100; dflow_addr_high = 19'h200;
        n0 = nwr; p0 = npop; b = seq;
        push(20);
        start_store = 1'b1;
        k = 0;
        while ((npop - p0) < 5 && k < 30) begin tick(); k++; end
        if ((npop - p0) < 5) check_eq("timeout_burst", 144'(npop - p0), 144'(5));
        start_store = 1'b0;
        repeat (12) tick();
        @(negedge clk);
        check_eq("bs_nwr", 144'(nwr - n0), 144'(8));
        check_eq("bs_npop", 144'(npop - p0), 144'(8));
        check_eq("bs_last_addr", 144'(waddr[n0 + 7]), 144'(19'h107));
        check_eq("bs_left", 144'(wr_ptr - rd_ptr), 144'(12));
        check_eq("bs_done", 144'(store_done), 144'(0));
        check_eq("bs_idle", 144'(app_wr_cmd), 144'(0));
        end_run();

        // cal_done gating
        dflow_addr_low = 19'h30; dflow_addr_high = 19'h40;
        cal_done = 1'b0;
        n0 = nwr; p0 = npop; b = seq;
        push(3);
        start_store = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check_eq("cal_nopop", 144'(npop - p0), 144'(0));
        check_eq("cal_nowr", 144'(nwr - n0), 144'(0));
        check_eq("cal_cmd0", 144'(app_wr_cmd), 144'(0));
        tick();
        cal_done = 1'b1;
        @(negedge clk);
        check_eq("cal_rden", 144'(fifo_rd_en), 144'(1));
        check_eq("cal_cmd_pre", 144'(app_wr_cmd), 144'(0));
        tick();
        @(negedge clk);
        check_eq("cal_cmd", 144'(app_wr_cmd), 144'(1));
        check_eq("cal_addr", 144'(app_wr_addr), 144'(19'h30));
        check_eq("cal_data", app_wr_data, mk(b));
        end_run();

        // Soft reset with a write pending
        dflow_addr_low = 19'h50; dflow_addr_high = 19'h60;
        app_wr_rdy = 1'b0;
        b = seq;
        push(4);
        start_store = 1'b1;
        k = 0;
        while (!app_wr_cmd && k < 20) begin tick(); k++; end
        if (!app_wr_cmd) check_eq("timeout_swrst", 144'(app_wr_cmd), 144'(1));
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        check_eq("sw_cmd", 144'(app_wr_cmd), 144'(0));
        check_eq("sw_addr", 144'(app_wr_addr), 144'(0));
        check_eq("sw_idle_rden", 144'(fifo_rd_en), 144'(0));
        check_eq("sw_memhigh", 144'(dflow_mem_high), 144'(19'h50));
        check_eq("sw_done", 144'(store_done), 144'(0));
        n0 = nwr;
        app_wr_rdy = 1'b1;
        wait_writes(n0 + 1, 20);
        tick();
        check_eq("sw_restart_addr", 144'(waddr[n0]), 144'(19'h50));
        check_eq("sw_restart_data", wdata[n0], mk(b + 1));
        end_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
